// File: rtl/lcd_bus_arbiter_pkg.sv
`default_nettype none
// lcd_bus_arbiter_pkg: bus FSM states, idle pin levels and default strobe timing.
// Revision: 1.0
package lcd_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  localparam logic CS_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;
  localparam logic RS_IDLE = 1'b1;
  localparam logic OE_IDLE = 1'b1;

  localparam int DEF_DW         = 16;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 1;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_MAX_BURST  = 854;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// lcd_bus_arbiter_if: command/pixel handshakes and LCD pins; LCD_RD_EN adds the read path.
// Revision: 1.0
interface lcd_bus_arbiter_if #(
  parameter int DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rs;
  logic [DW-1:0] cmd_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] pix_data;
  logic          pix_last;
  logic [DW-1:0] lcd_data;
  logic          cs;
  logic          rs;
  logic          wr;
  logic          rd;
`ifdef LCD_RD_EN
  logic          cmd_rnw;
  logic [DW-1:0] lcd_din;
  logic          lcd_oe;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
`endif

  modport master (
    output cmd_valid, cmd_rs, cmd_data, pix_valid, pix_data, pix_last,
`ifdef LCD_RD_EN
    output cmd_rnw, lcd_din,
    input  lcd_oe, rd_data, rd_valid,
`endif
    input  cmd_ready, pix_ready, lcd_data, cs, rs, wr, rd
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, pix_valid, pix_data, pix_last,
`ifdef LCD_RD_EN
    input  cmd_rnw, lcd_din,
    output lcd_oe, rd_data, rd_valid,
`endif
    output cmd_ready, pix_ready, lcd_data, cs, rs, wr, rd
  );

endinterface
`default_nettype wire

// File: rtl/lcd_bus_arbiter_phase_timer.sv
`default_nettype none
// lcd_bus_arbiter_phase_timer: per-state cycle counter, loaded on state entry, flags the last cycle.
// Revision: 1.0
module lcd_bus_arbiter_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] remain;

  // Saturates at zero so a state that outlives its count just keeps flagging last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      remain <= '0;
    end else if (load) begin
      remain <= load_val - 1'b1;
    end else if (remain != '0) begin
      remain <= remain - 1'b1;
    end
  end

  assign last = (remain == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// lcd_bus_arbiter: shares an 8080 LCD bus between a command port and a locked pixel stream.
// Revision: 1.0 -- define LCD_RD_EN to add command read cycles.
module lcd_bus_arbiter
  import lcd_bus_arbiter_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset,
  lcd_bus_arbiter_if.slave bus
);

  localparam int TW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC);
  localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYC);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

  bus_state_t    state, state_nx;
  logic          t_load, t_last;
  logic [TW-1:0] t_val;
  logic          cmd_ready_q, pix_ready_q, cmd_ready_nx, pix_ready_nx;
  logic          cmd_hs, pix_hs;
  logic          lock_q;
  logic [BW-1:0] burst_q;
  logic          cs_q, wr_q, rs_q, wr_nx;
  logic [DW-1:0] data_q;

  assign cmd_hs = (state == IDLE) && cmd_ready_q && bus.cmd_valid;
  assign pix_hs = (state == IDLE) && pix_ready_q && bus.pix_valid;

  lcd_bus_arbiter_phase_timer #(.CW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .last     (t_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      state       <= state_nx;
      cmd_ready_q <= cmd_ready_nx;
      pix_ready_q <= pix_ready_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    t_load       = 1'b0;
    t_val        = SETUP_LD;
    cmd_ready_nx = 1'b0;
    pix_ready_nx = 1'b0;
    case (state)
      IDLE: if (cmd_hs || pix_hs) begin
        state_nx = SETUP;
        t_load   = 1'b1;
        t_val    = SETUP_LD;
      end
      SETUP: if (t_last) begin
        state_nx = STROBE;
        t_load   = 1'b1;
        t_val    = STROBE_LD;
      end
      STROBE: if (t_last) begin
        state_nx = HOLD;
        t_load   = 1'b1;
        t_val    = HOLD_LD;
      end
      HOLD: if (t_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Grant for the coming idle cycle; a held lock shuts the command port out.
    if (state_nx == IDLE) begin
      if (lock_q) begin
        pix_ready_nx = bus.pix_valid;
      end else if (bus.cmd_valid) begin
        cmd_ready_nx = 1'b1;
      end else begin
        pix_ready_nx = bus.pix_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q  <= 1'b0;
      burst_q <= '0;
    end else if (pix_hs) begin
      if (bus.pix_last || (burst_q == BURST_END)) begin
        lock_q  <= 1'b0;
        burst_q <= '0;
      end else begin
        lock_q  <= 1'b1;
        burst_q <= burst_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      rs_q   <= RS_IDLE;
    end else if (cmd_hs) begin
      data_q <= bus.cmd_data;
      rs_q   <= bus.cmd_rs;
    end else if (pix_hs) begin
      data_q <= bus.pix_data;
      rs_q   <= 1'b1;
    end
  end

`ifdef LCD_RD_EN
  logic          rnw_q, rnw_nx, rd_q, rd_nx, oe_q, rd_valid_q, sample;
  logic [DW-1:0] rd_data_q;

  assign rnw_nx = (state == IDLE) ? (cmd_hs && bus.cmd_rnw) : rnw_q;
  assign wr_nx  = !((state_nx == STROBE) && !rnw_nx);
  assign rd_nx  = !((state_nx == STROBE) && rnw_nx);
  assign sample = (state == STROBE) && t_last && rnw_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rnw_q      <= 1'b0;
      rd_q       <= RD_IDLE;
      oe_q       <= OE_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rnw_q      <= rnw_nx;
      rd_q       <= rd_nx;
      oe_q       <= !(rnw_nx && (state_nx != IDLE));
      rd_valid_q <= sample;
      if (sample) rd_data_q <= bus.lcd_din;
    end
  end

  assign bus.rd       = rd_q;
  assign bus.lcd_oe   = oe_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
`else
  assign wr_nx  = (state_nx != STROBE);
  assign bus.rd = RD_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q <= CS_IDLE;
      wr_q <= WR_IDLE;
    end else begin
      cs_q <= (state_nx == IDLE);
      wr_q <= wr_nx;
    end
  end

  assign bus.cs        = cs_q;
  assign bus.wr        = wr_q;
  assign bus.rs        = rs_q;
  assign bus.lcd_data  = data_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.pix_ready = pix_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// tb_lcd_bus_arbiter: directed scenarios plus randomized traffic against a cycle-position model.
// Revision: 1.0
module tb_lcd_bus_arbiter;

  localparam int DW = 16;
  localparam int S  = 1;
  localparam int ST = 1;
  localparam int H  = 1;
  localparam int MB = 8;
  localparam int WORD = S + ST + H;

  typedef struct { logic [DW-1:0] d; logic rs; logic rnw; } cmd_t;
  typedef struct { logic [DW-1:0] d; logic last; } pix_t;
  typedef struct { logic [DW-1:0] d; logic rs; int cyc; } strobe_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_arbiter_if #(.DW(DW)) bus ();

  lcd_bus_arbiter #(
    .DW(DW), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .MAX_BURST(MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- source driver ----------------
  cmd_t cmd_q[$];
  pix_t pix_q[$];
  bit rand_mode = 1'b0;
  bit cmd_gate = 1'b1, pix_gate = 1'b1;
  bit cmd_fire_s = 1'b0, pix_fire_s = 1'b0;
  logic [DW-1:0] din_fixed = '0;

  always @(posedge clk) begin
    cmd_fire_s = reset && bus.cmd_valid && bus.cmd_ready;
    pix_fire_s = reset && bus.pix_valid && bus.pix_ready;
  end

  always begin
    cmd_t c;
    pix_t p;
    @(negedge clk);
    #1;
    if (cmd_fire_s && cmd_q.size() > 0) cmd_q.delete(0);
    if (pix_fire_s && pix_q.size() > 0) pix_q.delete(0);
    if (rand_mode) begin
      cmd_gate = ($urandom_range(0, 3) != 0);
      pix_gate = ($urandom_range(0, 3) != 0);
      if (cmd_q.size() < 3 && $urandom_range(0, 5) == 0) begin
        c.d   = DW'($urandom);
        c.rs  = 1'($urandom);
        c.rnw = ($urandom_range(0, 3) == 0);
        cmd_q.push_back(c);
      end
      if (pix_q.size() < 6 && $urandom_range(0, 1) == 0) begin
        p.d    = DW'($urandom);
        p.last = ($urandom_range(0, 5) == 0);
        pix_q.push_back(p);
      end
      din_fixed = DW'($urandom);
    end else begin
      cmd_gate = 1'b1;
      pix_gate = 1'b1;
    end
    bus.cmd_valid = cmd_gate && (cmd_q.size() > 0);
    if (cmd_q.size() > 0) begin
      bus.cmd_data = cmd_q[0].d;
      bus.cmd_rs   = cmd_q[0].rs;
`ifdef LCD_RD_EN
      bus.cmd_rnw  = cmd_q[0].rnw;
`endif
    end
    bus.pix_valid = pix_gate && (pix_q.size() > 0);
    if (pix_q.size() > 0) begin
      bus.pix_data = pix_q[0].d;
      bus.pix_last = pix_q[0].last;
    end
`ifdef LCD_RD_EN
    bus.lcd_din = din_fixed;
`endif
  end

  // ---------------- behavioural model ----------------
  // m_pos counts cycles since the accepting edge: 0 idle, 1..WORD inside a word.
  int   m_pos = 0, m_cnt = 0, cyc = 0;
  bit   m_lock = 1'b0, m_rnw = 1'b0, m_started = 1'b0;
  logic e_cs = 1, e_wr = 1, e_rd = 1, e_rs = 1, e_cr = 0, e_pr = 0, e_oe = 1, e_rdv = 0;
  logic [DW-1:0] e_data = '0, e_rdd = '0;

  always @(posedge clk) begin
    bit c_fire, p_fire, strobe, in_valid_cmd;
    cyc++;
    if (!reset) begin
      m_pos = 0; m_cnt = 0; m_lock = 0; m_rnw = 0;
      e_data = '0; e_rs = 1; e_cr = 0; e_pr = 0; e_rdd = '0;
    end else begin
      c_fire = e_cr && bus.cmd_valid;
      p_fire = e_pr && bus.pix_valid;
`ifdef LCD_RD_EN
      if (m_rnw && m_pos == S + ST) e_rdd = bus.lcd_din;
`endif
      if (m_pos != 0) m_pos = (m_pos == WORD) ? 0 : m_pos + 1;
      if (c_fire) begin
        m_pos = 1; e_data = bus.cmd_data; e_rs = bus.cmd_rs;
`ifdef LCD_RD_EN
        m_rnw = bus.cmd_rnw;
`else
        m_rnw = 0;
`endif
      end else if (p_fire) begin
        m_pos = 1; e_data = bus.pix_data; e_rs = 1; m_rnw = 0;
        m_cnt++;
        if (bus.pix_last || m_cnt == MB) begin m_lock = 0; m_cnt = 0; end
        else m_lock = 1;
      end
      in_valid_cmd = bus.cmd_valid;
      e_cr = 0; e_pr = 0;
      if (m_pos == 0) begin
        if (m_lock) e_pr = bus.pix_valid;
        else if (in_valid_cmd) e_cr = 1;
        else e_pr = bus.pix_valid;
      end
    end
    strobe = (m_pos > S) && (m_pos <= S + ST);
    e_cs  = (m_pos == 0);
    e_wr  = !(strobe && !m_rnw);
    e_rd  = !(strobe && m_rnw);
    e_oe  = !(m_pos != 0 && m_rnw);
    e_rdv = m_rnw && (m_pos == S + ST + 1);
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("bus_ctl", {bus.cs, bus.wr, bus.rd, bus.rs, bus.cmd_ready, bus.pix_ready},
                       {e_cs, e_wr, e_rd, e_rs, e_cr, e_pr});
      check("bus_data", bus.lcd_data, e_data);
`ifdef LCD_RD_EN
      check("rd_path", {bus.lcd_oe, bus.rd_valid, bus.rd_data}, {e_oe, e_rdv, e_rdd});
`endif
    end
  end

  // ---------------- strobe log ----------------
  strobe_t log_q[$];
  logic prev_wr = 1'b1;
  always @(negedge clk) begin
    strobe_t s;
    if (prev_wr && !bus.wr) begin
      s.d = bus.lcd_data; s.rs = bus.rs; s.cyc = cyc;
      log_q.push_back(s);
    end
    prev_wr = bus.wr;
  end

`ifdef LCD_RD_EN
  int rd_low = 0, oe_low = 0;
  always @(negedge clk) begin
    if (!bus.rd) rd_low++;
    if (!bus.lcd_oe) oe_low++;
  end
`endif

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
    if (log_q.size() < n) begin
      total++; bad++;
      $display("FAIL %s: timeout strobes=%0d need=%0d", name, log_q.size(), n);
    end
  endtask

  task automatic push_cmd(input logic [DW-1:0] d, input logic rs, input logic rnw);
    cmd_t c;
    c.d = d; c.rs = rs; c.rnw = rnw;
    cmd_q.push_back(c);
  endtask

  task automatic push_pix(input logic [DW-1:0] d, input logic last);
    pix_t p;
    p.d = d; p.last = last;
    pix_q.push_back(p);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [DW-1:0] t2_data [5];
    logic          t2_rs   [5];
    int k;
    t2_data = '{16'h002A, 16'h0000, 16'h0000, 16'h0003, 16'h0055};
    t2_rs   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus.cmd_valid = 0; bus.cmd_rs = 0; bus.cmd_data = '0;
    bus.pix_valid = 0; bus.pix_data = '0; bus.pix_last = 0;
`ifdef LCD_RD_EN
    bus.cmd_rnw = 0; bus.lcd_din = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", {bus.cs, bus.wr, bus.rd, bus.rs, bus.lcd_data, bus.cmd_ready, bus.pix_ready},
                         {4'b1111, 16'h0000, 2'b00});
    reset = 1'b1;

    // Reset mid-strobe drops the word.
    @(negedge clk);
    push_cmd(16'h1234, 1'b0, 1'b0);
    k = 0;
    while (bus.wr && k < 20) begin @(negedge clk); k++; end
    check("t1_strobe_seen", bus.wr, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("t1_abort", {bus.cs, bus.wr, bus.rd, bus.rs, bus.lcd_data, bus.cmd_ready, bus.pix_ready},
                      {4'b1111, 16'h0000, 2'b00});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    log_q.delete();
    repeat (10) @(negedge clk);
    check("t1_no_retry", log_q.size(), 0);

    // Five command-port words back to back.
    log_q.delete();
    for (int i = 0; i < 5; i++) push_cmd(t2_data[i], t2_rs[i], 1'b0);
    wait_log(5, 80, "t2_wait");
    if (log_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t2_data", log_q[i].d, t2_data[i]);
        check("t2_rs", log_q[i].rs, t2_rs[i]);
      end
      for (int i = 1; i < 5; i++) check("t2_period", log_q[i].cyc - log_q[i-1].cyc, 4);
    end
    repeat (6) @(negedge clk);

    // Simultaneous requests with no lock: command first.
    log_q.delete();
    push_cmd(16'h00AA, 1'b1, 1'b0);
    push_pix(16'hF800, 1'b1);
    wait_log(2, 40, "t3_wait");
    if (log_q.size() >= 2) begin
      check("t3_first", {log_q[0].rs, log_q[0].d}, {1'b1, 16'h00AA});
      check("t3_second", {log_q[1].rs, log_q[1].d}, {1'b1, 16'hF800});
    end
    repeat (6) @(negedge clk);

    // Locked 4-pixel line, command arrives after the first pixel.
    log_q.delete();
    for (int i = 0; i < 4; i++) push_pix(DW'(16'h1000 + i), i == 3);
    wait_log(1, 40, "t4_wait1");
    push_cmd(16'h002C, 1'b0, 1'b0);
    wait_log(5, 80, "t4_wait");
    if (log_q.size() >= 5) begin
      check("t4_pix3", log_q[3].d, 16'h1003);
      check("t4_cmd", {log_q[4].rs, log_q[4].d}, {1'b0, 16'h002C});
    end
    repeat (6) @(negedge clk);

    // No pix_last: lock is forced open after MB pixels.
    log_q.delete();
    for (int i = 0; i < 10; i++) push_pix(DW'(16'h2000 + i), 1'b0);
    wait_log(1, 40, "t5_wait1");
    push_cmd(16'h0036, 1'b0, 1'b0);
    wait_log(11, 200, "t5_wait");
    if (log_q.size() >= 11) begin
      check("t5_pix7", log_q[7].d, 16'h2007);
      check("t5_cmd", {log_q[8].rs, log_q[8].d}, {1'b0, 16'h0036});
      check("t5_pix8", log_q[9].d, 16'h2008);
    end
    repeat (6) @(negedge clk);

`ifdef LCD_RD_EN
    // Read cycle: rd strobe only, bus released for the whole word.
    push_pix(16'h0000, 1'b1);
    repeat (10) @(negedge clk);
    log_q.delete();
    din_fixed = 16'h009C;
    rd_low = 0; oe_low = 0;
    push_cmd(16'h000A, 1'b0, 1'b1);
    k = 0;
    while (!bus.rd_valid && k < 30) begin @(negedge clk); k++; end
    check("t6_rd_valid", bus.rd_valid, 1'b1);
    check("t6_rd_data", bus.rd_data, 16'h009C);
    repeat (6) @(negedge clk);
    check("t6_rd_low", rd_low, 1);
    check("t6_oe_low", oe_low, WORD);
    check("t6_no_wr", log_q.size(), 0);
`endif

    // Randomized traffic with one reset pulse in the middle.
    rand_mode = 1'b1;
    repeat (1500) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (1500) @(negedge clk);
    rand_mode = 1'b0;
    push_pix(16'hBEEF, 1'b1);
    k = 0;
    while ((cmd_q.size() > 0 || pix_q.size() > 0) && k < 1000) begin @(negedge clk); k++; end
    check("drain", cmd_q.size() + pix_q.size(), 0);
    repeat (8) @(negedge clk);
    check("final_idle", {bus.cs, bus.wr, bus.rd}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
